fs_16bit_serial: RTL and testbench

//  Bit-serial subtractor: the inverse operation of the 16-bit ripple full adder. It computes
//  d = a - b - bin with one full-subtractor cell, LSB first, one bit per clock.

---
 rtl/fs_pkg.sv | 12 +
 rtl/fs_1bit.sv | 13 +
 rtl/fs_16bit_serial.sv | 136 +++++++++++++
 tb/tb_fs_16bit_serial.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fs_pkg.sv
// Shared types and defaults for the bit-serial full-subtractor datapath.
package fs_pkg;

  localparam int FS_DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } fs_state_t;

endpackage

// File: rtl/fs_1bit.sv
// Combinational full-subtractor cell: diff = x - y - bi, bo = borrow out.
module fs_1bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/fs_16bit_serial.sv
// Bit-serial subtractor d = a - b - bin, LSB first through one fs_1bit cell.
// Optional signed-overflow flag is built only when SUB_OVF_EN is defined.
//
// state  | meaning
// S_IDLE | in_ready=1, waiting for operands
// S_BUSY | one difference bit per clock, WIDTH cycles
// S_DONE | out_valid=1, result held until out_ready
module fs_16bit_serial
  import fs_pkg::*;
#(
  parameter int WIDTH = FS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  fs_state_t        state;
  fs_state_t        state_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] diff_sr;
  logic             borrow;
  logic             cell_diff;
  logic             cell_bo;
  logic             last_bit;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;

  fs_1bit u_cell (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bi   (borrow),
    .diff (cell_diff),
    .bo   (cell_bo)
  );

  assign last_bit = (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operands shift right so the cell always sees bit 0; the difference
  // enters from the MSB side and the last bit completes the word in d_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      borrow  <= 1'b0;
      d_q     <= '0;
      bout_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b;
            borrow <= bin;
            count  <= '0;
          end
        end
        S_BUSY: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= (WIDTH-1)'({cell_diff, diff_sr} >> 1);
          borrow  <= cell_bo;
          if (last_bit) begin
            d_q    <= {cell_diff, diff_sr};
            bout_q <= cell_bo;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign d    = d_q;
  assign bout = bout_q;

`ifdef SUB_OVF_EN
  logic ovf_q;

  // On the last bit the shift registers present the operand sign bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == S_BUSY && last_bit) begin
      ovf_q <= (a_sr[0] != b_sr[0]) && (cell_diff != a_sr[0]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fs_16bit_serial.sv
// Self-checking bench for fs_16bit_serial: directed cases plus random ops
// against an arithmetic model, with a per-cycle output monitor.
module tb_fs_16bit_serial;

  localparam int W   = 16;
  localparam int LAT = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] d;
  logic         bout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  fs_16bit_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result packed as {d, bout, ovf}.
  function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
    logic [W:0] full;
    logic       sovf;
    full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
`ifdef SUB_OVF_EN
    sovf = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
`else
    sovf = 1'b0;
`endif
    return {full[W-1:0], full[W], sovf};
  endfunction

  // Monitor: expected results queued at accept, checked every cycle.
  logic [W+1:0] exp_q[$];
  int           acc_q[$];
  logic [W+1:0] hold = '0;
  bit           seen = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      hold = '0;
      seen = 0;
    end else begin
      chk("mon_in_ready", in_ready, exp_q.size() == 0);
      if (exp_q.size() == 0) begin
        chk("mon_out_valid_idle", out_valid, 0);
      end else if (!seen) begin
        chk("mon_latency", out_valid, (cyc - acc_q[0]) == LAT);
      end else begin
        chk("mon_out_valid_held", out_valid, 1);
      end
      if (out_valid && exp_q.size() != 0) begin
        seen = 1;
        chk("mon_result", {d, bout, ovf}, exp_q[0]);
      end else begin
        chk("mon_hold", {d, bout, ovf}, hold);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        hold = exp_q.pop_front();
        void'(acc_q.pop_front());
        seen = 0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, bin));
        acc_q.push_back(cyc + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                        input int stall, input bit poke, output logic [W+1:0] res);
    int n;
    in_valid = 1'b1;
    a = ta;
    b = tb;
    bin = tbin;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("accept_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      out_ready = 1'($urandom);
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("result_wait", out_valid, 1);
    res = {d, bout, ovf};
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        in_valid = (i == 2);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+1:0] r;
    logic         exp_ovf3;
    logic [W-1:0] ra, rb;
    int           pick;

    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d", d, 0);
    chk("rst_bout", bout, 0);
    chk("rst_ovf", ovf, 0);
    tick();

    run_op(16'h1234, 16'h0235, 1'b1, 0, 0, r);
    chk("t1_d", r[W+1:2], 16'h0FFE);
    chk("t1_bout", r[1], 0);
    chk("t1_ovf", r[0], 0);

    run_op(16'h0000, 16'h0001, 1'b0, 1, 0, r);
    chk("t2a_d", r[W+1:2], 16'hFFFF);
    chk("t2a_bout", r[1], 1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 0, r);
    chk("t2b_d", r[W+1:2], 16'hFFFF);
    chk("t2b_bout", r[1], 1);

`ifdef SUB_OVF_EN
    exp_ovf3 = 1'b1;
`else
    exp_ovf3 = 1'b0;
`endif
    run_op(16'h8000, 16'h0001, 1'b0, 0, 0, r);
    chk("t3_d", r[W+1:2], 16'h7FFF);
    chk("t3_bout", r[1], 0);
    chk("t3_ovf", r[0], exp_ovf3);

    run_op(16'h1234, 16'h0235, 1'b1, 5, 1, r);
    chk("t4_d", r[W+1:2], 16'h0FFE);
    chk("t4_bout", r[1], 0);

    // Reset on the 7th BUSY cycle.
    in_valid = 1'b1;
    a = 16'hABCD;
    b = 16'h1111;
    bin = 1'b0;
    chk("t5_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_d", d, 0);
    chk("t5_bout", bout, 0);
    chk("t5_in_ready", in_ready, 1);
    run_op(16'h0005, 16'h0003, 1'b0, 0, 0, r);
    chk("t5_next_d", r[W+1:2], 16'h0002);
    chk("t5_next_bout", r[1], 0);

    for (int k = 0; k < 1000; k++) begin
      pick = $urandom_range(0, 7);
      ra = (pick == 0) ? 16'h0000 : (pick == 1) ? 16'hFFFF : (pick == 2) ? 16'h8000 : W'($urandom);
      pick = $urandom_range(0, 7);
      rb = (pick == 0) ? 16'h0000 : (pick == 1) ? 16'hFFFF : (pick == 2) ? 16'h7FFF : W'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 0, r);
    end

    // Back-to-back issue with out_ready tied high.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      for (int n = 0; n < 100 && !in_ready; n++) tick();
      chk("b2b_accept", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (LAT + 4) tick();
    out_ready = 1'b0;
    chk("final_idle", in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
